alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
// - Pipeline stage directly downstream of the ALU units (logic, arith, shift, compare) in ALU_TOP.
// - Selects one unit's result per op, derives status flags and registers result+flags+dest tag.
// - valid/ready handshake with a 2-entry skid buffer, so in_ready is a pure register output.
// - Feeds the writeback stage; one registered cycle of latency.
// PARAMETERS
// - DATA_W  32  result width (unit outputs, out_result)
// - TAG_W   5   destination register tag width
// - CNT_W   16  retired-op counter width
// PORTS
// - clk             in   1       single clock; all state updates on rising edge
// - rst             in   1       synchronous, active-high reset
// - in_valid        in   1       upstream op valid this cycle
// - in_ready        out  1       stage can accept; transfer when in_valid & in_ready
// - in_unit_sel     in   2       00 logic, 01 arith, 10 shift, 11 compare
// - in_logic_data   in   DATA_W  logic unit result (AND/OR/XOR/NOR)
// - in_arith_data   in   DATA_W  add/sub unit result
// - in_shift_data   in   DATA_W  shifter result
// - in_cmp_data     in   DATA_W  compare result (0 or 1, zero-extended)
// - in_carry        in   1       arith carry-out
// - in_overflow     in   1       arith signed overflow
// - in_dest         in   TAG_W   destination tag, passed through unchanged
// - out_valid       out  1       result valid toward writeback
// - out_ready       in   1       downstream accept; transfer when out_valid & out_ready
// - out_result      out  DATA_W  selected result
// - out_zero        out  1       out_result == 0
// - out_neg         out  1       out_result[DATA_W-1]
// - out_carry       out  1       in_carry if unit==arith, else 0
// - out_ovf         out  1       in_overflow if unit==arith, else 0
// - out_dest        out  TAG_W   destination tag
// - out_retired_cnt out  CNT_W   count of output transfers, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset (rst high at edge): out_valid=0, in_ready=0 while rst high, 1 the cycle after; out_result,
//   flags, out_dest, out_retired_cnt = 0; skid entry cleared. rst mid-operation drops all held ops.
// - Flags computed from the selected input on capture (not recomputed at output); registered with result.
// - Storage: main reg (drives outputs) + skid reg. States by occupancy:
//   EMPTY: in_valid&in_ready -> load main -> ONE.
//   ONE: accept & out xfer -> reload main, stay ONE; accept only -> load skid -> FULL;
//        out xfer only -> EMPTY; neither -> hold.
//   FULL: in_ready=0; out xfer -> skid moves to main -> ONE; else hold all.
// - in_ready registered: 1 in EMPTY/ONE, 0 in FULL (and during rst). No input is lost/duplicated.
// - Latency: op accepted in cycle N appears on outputs in cycle N+1 if main free; order strictly FIFO.
// - Outputs stable while out_valid & ~out_ready (no change of result/flags/dest).
// - out_retired_cnt increments by 1 per output transfer; 2^CNT_W-1 -> 0 wrap, no flag.
// - Simultaneous in/out transfer in ONE: throughput 1 op/cycle, counter +1.
// - in_unit_sel sampled only on accepted transfers; other cycles' inputs are don't-care.
// STRUCTURE
// - Shared package alu_pkg: unit_sel encodings (UNIT_LOGIC/ARITH/SHIFT/CMP), DATA_W/TAG_W defaults,
//   packed result record {result, zero, neg, carry, ovf, dest} used by main and skid regs.
// - One sub-module: alu_flag_gen (combinational) - unit mux + zero/neg/carry/ovf derivation.
// - Top holds occupancy FSM, main/skid regs, counter.
// TESTING
// - Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, cnt=0; cycle after, in_ready=1.
// - Logic pass: sel=00, logic=0xF0F0_0000, out_ready=1 -> next cycle result 0xF0F0_0000, neg=1, zero=0,
//   carry=ovf=0 even with in_carry=1.
// - Arith flags: sel=01, arith=0x0000_0000, carry=1, ovf=1 -> zero=1, carry=1, ovf=1, dest passed.
// - Backpressure: out_ready=0, push ops A,B -> in_ready=0 after B; C held off; out_ready=1 -> A, B, C
//   in order, no drop/dup, cnt=3.
// - Streaming: out_ready=1, 100 back-to-back ops -> one output per cycle, cnt=100.
// - Wrap/reset mid-op: preload cnt to 0xFFFF, one xfer -> 0x0000; rst with FULL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, unit encodings and result record for the ALU result stage
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    UNIT_LOGIC = 2'b00,
    UNIT_ARITH = 2'b01,
    UNIT_SHIFT = 2'b10,
    UNIT_CMP   = 2'b11
  } unit_sel_t;

  // Everything that travels together through the main and skid registers.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              neg;
    logic              carry;
    logic              ovf;
    logic [TAG_W-1:0]  dest;
  } result_rec_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - upstream/downstream handshake bundle of the ALU result stage
interface alu_result_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  unit_sel_t         in_unit_sel;
  logic [DATA_W-1:0] in_logic_data;
  logic [DATA_W-1:0] in_arith_data;
  logic [DATA_W-1:0] in_shift_data;
  logic [DATA_W-1:0] in_cmp_data;
  logic              in_carry;
  logic              in_overflow;
  logic [TAG_W-1:0]  in_dest;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_neg;
  logic              out_carry;
  logic              out_ovf;
  logic [TAG_W-1:0]  out_dest;
  logic [CNT_W-1:0]  out_retired_cnt;

  modport master (
    output in_valid, in_unit_sel, in_logic_data, in_arith_data, in_shift_data,
           in_cmp_data, in_carry, in_overflow, in_dest, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
           out_ovf, out_dest, out_retired_cnt
  );

  modport slave (
    input  in_valid, in_unit_sel, in_logic_data, in_arith_data, in_shift_data,
           in_cmp_data, in_carry, in_overflow, in_dest, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
           out_ovf, out_dest, out_retired_cnt
  );

endinterface

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - unit result mux and status flag derivation (combinational)
module alu_flag_gen
  import alu_pkg::*;
(
  input  unit_sel_t         unit_sel,
  input  logic [DATA_W-1:0] logic_data,
  input  logic [DATA_W-1:0] arith_data,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [DATA_W-1:0] cmp_data,
  input  logic              carry,
  input  logic              overflow,
  input  logic [TAG_W-1:0]  dest,
  output result_rec_t       rec
);

  logic [DATA_W-1:0] sel_data;

  always_comb begin
    sel_data = logic_data;
    case (unit_sel)
      UNIT_LOGIC: sel_data = logic_data;
      UNIT_ARITH: sel_data = arith_data;
      UNIT_SHIFT: sel_data = shift_data;
      UNIT_CMP:   sel_data = cmp_data;
      default:    sel_data = logic_data;
    endcase
  end

  // Carry/overflow only mean something for add/sub; other units report them clear.
  always_comb begin
    rec        = '0;
    rec.result = sel_data;
    rec.zero   = (sel_data == '0);
    rec.neg    = sel_data[DATA_W-1];
    rec.carry  = (unit_sel == UNIT_ARITH) & carry;
    rec.ovf    = (unit_sel == UNIT_ARITH) & overflow;
    rec.dest   = dest;
  end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with 2-entry skid buffer and retire counter
module alu_result_stage
  import alu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state, state_n;
  result_rec_t      cap_rec, main_q, skid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, oxfer, load_main, load_skid, skid_to_main;

  alu_flag_gen u_flag_gen (
    .unit_sel   (bus.in_unit_sel),
    .logic_data (bus.in_logic_data),
    .arith_data (bus.in_arith_data),
    .shift_data (bus.in_shift_data),
    .cmp_data   (bus.in_cmp_data),
    .carry      (bus.in_carry),
    .overflow   (bus.in_overflow),
    .dest       (bus.in_dest),
    .rec        (cap_rec)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign oxfer  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      ST_EMPTY: if (accept) begin
        load_main = 1'b1;
        state_n   = ST_ONE;
      end
      ST_ONE: begin
        if (accept && oxfer) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_n   = ST_FULL;
        end else if (oxfer) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: if (oxfer) begin
        skid_to_main = 1'b1;
        state_n      = ST_ONE;
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next occupancy so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != ST_FULL);
      if (load_main) begin
        main_q <= cap_rec;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= cap_rec;
      end
      if (oxfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = (state != ST_EMPTY);
  assign bus.out_result      = main_q.result;
  assign bus.out_zero        = main_q.zero;
  assign bus.out_neg         = main_q.neg;
  assign bus.out_carry       = main_q.carry;
  assign bus.out_ovf         = main_q.ovf;
  assign bus.out_dest        = main_q.dest;
  assign bus.out_retired_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [40:0] sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_rec = '0;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [40:0] model(input logic [1:0] sel, input logic [31:0] l, input logic [31:0] a,
                                        input logic [31:0] s, input logic [31:0] c, input logic cy,
                                        input logic ov, input logic [4:0] d);
    logic [31:0] r;
    logic        is_arith;
    r = (sel == 2'd0) ? l : (sel == 2'd1) ? a : (sel == 2'd2) ? s : c;
    is_arith = (sel == 2'd1);
    return {r, (r == 32'd0), r[31], cy & is_arith, ov & is_arith, d};
  endfunction

  function automatic logic [40:0] cur_out();
    return {bus.out_result, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf, bus.out_dest};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("retired_cnt", bus.out_retired_cnt, exp_cnt);
      if (prev_stall) check("stall_stable", {bus.out_valid, cur_out()}, prev_rec);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("result_rec", cur_out(), sb.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_unit_sel, bus.in_logic_data, bus.in_arith_data, bus.in_shift_data,
                           bus.in_cmp_data, bus.in_carry, bus.in_overflow, bus.in_dest));
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_rec   = {bus.out_valid, cur_out()};
    end
  end

  task automatic send(input logic [1:0] sel, input logic [31:0] l, input logic [31:0] a, input logic [31:0] s,
                      input logic [31:0] c, input logic cy, input logic ov, input logic [4:0] d);
    bit done = 0;
    bus.in_unit_sel   = unit_sel_t'(sel);
    bus.in_logic_data = l;
    bus.in_arith_data = a;
    bus.in_shift_data = s;
    bus.in_cmp_data   = c;
    bus.in_carry      = cy;
    bus.in_overflow   = ov;
    bus.in_dest       = d;
    bus.in_valid      = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_rand();
    send(2'($urandom), $urandom, $urandom, $urandom, 32'($urandom_range(0, 1)),
         1'($urandom), 1'($urandom), 5'($urandom));
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !bus.out_valid) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    time t0;
    int  n_wrap;
    logic [CNT_W-1:0] c0;

    bus.in_valid      = 1'b1;
    bus.in_unit_sel   = UNIT_LOGIC;
    bus.in_logic_data = '0;
    bus.in_arith_data = '0;
    bus.in_shift_data = '0;
    bus.in_cmp_data   = '0;
    bus.in_carry      = 1'b0;
    bus.in_overflow   = 1'b0;
    bus.in_dest       = '0;
    bus.out_ready     = 1'b1;

    // reset held three cycles with in_valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_cnt", bus.out_retired_cnt, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // logic pass: carry/ovf suppressed
    send(2'b00, 32'hF0F0_0000, 32'h1234_5678, 32'h0, 32'h1, 1'b1, 1'b1, 5'd3);
    @(negedge clk);
    check("logic_valid", bus.out_valid, 1);
    check("logic_result", bus.out_result, 32'hF0F0_0000);
    check("logic_neg", bus.out_neg, 1);
    check("logic_zero", bus.out_zero, 0);
    check("logic_carry_ovf", {bus.out_carry, bus.out_ovf}, 2'b00);
    wait_drain();

    // arith flags
    send(2'b01, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 5'd17);
    @(negedge clk);
    check("arith_zero", bus.out_zero, 1);
    check("arith_carry", bus.out_carry, 1);
    check("arith_ovf", bus.out_ovf, 1);
    check("arith_dest", bus.out_dest, 5'd17);
    wait_drain();

    // backpressure: A, B fill the stage, C held off
    bus.out_ready = 1'b0;
    c0 = exp_cnt;
    send(2'b10, 32'h0, 32'h0, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0, 5'd1);
    send(2'b11, 32'h0, 32'h0, 32'h0, 32'h1, 1'b1, 1'b0, 5'd2);
    @(negedge clk);
    check("full_in_ready", bus.in_ready, 0);
    check("full_out_result", bus.out_result, 32'hAAAA_0001);
    fork
      send(2'b01, 32'h0, 32'h8000_0003, 32'h0, 32'h0, 1'b1, 1'b0, 5'd4);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_cnt_delta", 16'(exp_cnt - c0), 3);
    check("bp_dut_cnt_delta", 16'(bus.out_retired_cnt - c0), 3);

    // streaming: one op per cycle
    c0 = bus.out_retired_cnt;
    t0 = $time;
    repeat (100) send_rand();
    check("stream_cycles", ($time - t0) / 10, 100);
    wait_drain();
    check("stream_cnt_delta", 16'(bus.out_retired_cnt - c0), 100);

    // counter wrap
    n_wrap = 16'hFFFF - int'(exp_cnt);
    repeat (n_wrap) send_rand();
    wait_drain();
    check("cnt_max", bus.out_retired_cnt, 16'hFFFF);
    send_rand();
    wait_drain();
    check("cnt_wrap", bus.out_retired_cnt, 16'h0000);

    // reset while FULL
    bus.out_ready = 1'b0;
    send(2'b00, 32'h8765_4321, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd9);
    send(2'b01, 32'h0, 32'hFFFF_0000, 32'h0, 32'h0, 1'b1, 1'b1, 5'd10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rstfull_out_valid", bus.out_valid, 0);
    check("rstfull_rec", cur_out(), 41'd0);
    check("rstfull_cnt", bus.out_retired_cnt, 0);
    check("rstfull_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    send(2'b10, 32'h0, 32'h0, 32'h0000_00F0, 32'h0, 1'b0, 1'b0, 5'd5);
    wait_drain();
    check("rstfull_single_out", bus.out_retired_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
